stall_unit: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS-style core. It sits beside the ID stage. Each cycle it compares the decoded source registers against the destination registers of DEPTH downstream stages, and counts out fixed control-flow penalties for jumps and branches. It adds three behaviours: optional forwarding-aware (load-use only) RAW detection, register-0 exclusion, and a mid-stream flush. It also keeps a saturating stall-cycle statistic.

---
 rtl/stall_pkg.sv | 17 +
 rtl/raw_detect.sv | 40 ++++
 rtl/stall_unit.sv | 159 +++++++++++++++
 tb/tb_stall_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stall_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package stall_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        J_WAIT = 2'd1,
        B_WAIT = 2'd2
    } state_e;

    // Architectural zero register: writes to it are discarded, so it never creates a RAW hazard
    localparam int unsigned REG_ZERO = 0;

    // Default control-flow penalties, kept in step with the fetch unit
    localparam int unsigned DEF_J_PENALTY  = 1;
    localparam int unsigned DEF_BR_PENALTY = 3;

endpackage

// File: rtl/raw_detect.sv
// Combinational RAW hazard detector: compares ID sources against DEPTH downstream destinations.
module raw_detect
    import stall_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter int unsigned DEPTH  = 4,
    parameter bit          FWD_EN = 1'b0
) (
    input  logic [AW-1:0]       id_rs,
    input  logic [AW-1:0]       id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic [DEPTH*AW-1:0] wb_addr,
    input  logic [DEPTH-1:0]    wb_en,
    input  logic                ld_flag_ex,
    output logic                hazard
);

    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = wb_en[k]
                    && (wb_addr[k*AW +: AW] != AW'(REG_ZERO))
                    && ((id_uses_rs && (wb_addr[k*AW +: AW] == id_rs))
                     || (id_uses_rt && (wb_addr[k*AW +: AW] == id_rt)));
        end
    end

    // With forwarding only a load still in EX cannot be bypassed in time
    always_comb begin
        if (FWD_EN) begin
            hazard = match[0] && ld_flag_ex;
        end else begin
            hazard = |match;
        end
    end

endmodule

// File: rtl/stall_unit.sv
// ID-stage stall controller: RAW hazards, jump/branch penalties, flush and a saturating stall statistic.
module stall_unit
    import stall_pkg::*;
#(
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned J_PENALTY  = DEF_J_PENALTY,
    parameter int unsigned BR_PENALTY = DEF_BR_PENALTY,
    parameter bit          FWD_EN     = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                id_valid,
    input  logic [AW-1:0]       id_rs,
    input  logic [AW-1:0]       id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                id_jump,
    input  logic                id_branch,
    input  logic [DEPTH*AW-1:0] wb_addr,
    input  logic [DEPTH-1:0]    wb_en,
    input  logic [DEPTH-1:0]    ld_flag,
    input  logic                flush,
    input  logic                stat_clr,
    output logic                stall_j,
    output logic                stall_b,
    output logic                stall_raw,
    output logic                stall,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int unsigned PEN_MAX = (J_PENALTY > BR_PENALTY) ? J_PENALTY : BR_PENALTY;
    localparam int unsigned PCNT_W  = (PEN_MAX > 1) ? $clog2(PEN_MAX) : 1;

    state_e             state_q, state_d;
    logic [PCNT_W-1:0]  cnt_q, cnt_d;
    logic               stall_j_q, stall_j_d;
    logic               stall_b_q, stall_b_d;
    logic               stall_raw_q, stall_raw_d;
    logic               stall_q, stall_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               hazard;
    logic               unused_ld;

    // Only the EX-stage load flag matters; later stages are always forwardable
    assign unused_ld = ^ld_flag;

    raw_detect #(
        .AW     (AW),
        .DEPTH  (DEPTH),
        .FWD_EN (FWD_EN)
    ) u_raw_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .wb_addr    (wb_addr),
        .wb_en      (wb_en),
        .ld_flag_ex (ld_flag[0]),
        .hazard     (hazard)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_j_d   = stall_j_q;
        stall_b_d   = stall_b_q;
        stall_raw_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall_j_d = 1'b0;
                stall_b_d = 1'b0;
                if (id_valid && id_jump) begin
                    state_d   = J_WAIT;
                    cnt_d     = PCNT_W'(J_PENALTY - 1);
                    stall_j_d = 1'b1;
                end else if (id_valid && id_branch) begin
                    state_d   = B_WAIT;
                    cnt_d     = PCNT_W'(BR_PENALTY - 1);
                    stall_b_d = 1'b1;
                end else begin
                    stall_raw_d = id_valid && hazard;
                end
            end
            J_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    stall_j_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - PCNT_W'(1);
                end
            end
            B_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    stall_b_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - PCNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                stall_j_d = 1'b0;
                stall_b_d = 1'b0;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            stall_j_d   = 1'b0;
            stall_b_d   = 1'b0;
            stall_raw_d = 1'b0;
        end

        stall_d = stall_j_d | stall_b_d | stall_raw_d;
    end

    // Statistic counts cycles in which the registered stall was high
    always_comb begin
        cycles_d = cycles_q;
        if (stat_clr) begin
            cycles_d = '0;
        end else if (stall_q && (cycles_q != {CNT_W{1'b1}})) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_j_q   <= 1'b0;
            stall_b_q   <= 1'b0;
            stall_raw_q <= 1'b0;
            stall_q     <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_j_q   <= stall_j_d;
            stall_b_q   <= stall_b_d;
            stall_raw_q <= stall_raw_d;
            stall_q     <= stall_d;
            cycles_q    <= cycles_d;
        end
    end

    assign stall_j      = stall_j_q;
    assign stall_b      = stall_b_q;
    assign stall_raw    = stall_raw_q;
    assign stall        = stall_q;
    assign stall_cycles = cycles_q;

endmodule

// File: tb/tb_stall_unit.sv
// Scoreboard bench for stall_unit: two instances (full RAW / load-use only) share one stimulus stream.
module tb_stall_unit;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    logic                CLK = 1'b0;
    logic                RST;
    logic                id_valid;
    logic [AW-1:0]       id_rs, id_rt;
    logic                id_uses_rs, id_uses_rt;
    logic                id_jump, id_branch;
    logic [DEPTH*AW-1:0] wb_addr;
    logic [DEPTH-1:0]    wb_en, ld_flag;
    logic                flush, stat_clr;

    logic        j0, b0, raw0, st0;
    logic [3:0]  sc0;
    logic        j1, b1, raw1, st1;
    logic [15:0] sc1;

    always #5 CLK = ~CLK;

    stall_unit #(
        .AW(AW), .DEPTH(DEPTH), .J_PENALTY(1), .BR_PENALTY(3), .FWD_EN(1'b0), .CNT_W(4)
    ) dut0 (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .id_branch(id_branch), .wb_addr(wb_addr), .wb_en(wb_en), .ld_flag(ld_flag),
        .flush(flush), .stat_clr(stat_clr), .stall_j(j0), .stall_b(b0),
        .stall_raw(raw0), .stall(st0), .stall_cycles(sc0)
    );

    stall_unit #(
        .AW(AW), .DEPTH(DEPTH), .J_PENALTY(1), .BR_PENALTY(3), .FWD_EN(1'b1), .CNT_W(16)
    ) dut1 (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .id_branch(id_branch), .wb_addr(wb_addr), .wb_en(wb_en), .ld_flag(ld_flag),
        .flush(flush), .stat_clr(stat_clr), .stall_j(j1), .stall_b(b1),
        .stall_raw(raw1), .stall(st1), .stall_cycles(sc1)
    );

    typedef struct {
        logic  j;
        logic  b;
        logic  raw;
        logic  raw1;
        int    cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: every cycle the outputs settle, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "stall_j0",   int'(j0),   int'(e.j));
                chk(e.name, "stall_b0",   int'(b0),   int'(e.b));
                chk(e.name, "stall_raw0", int'(raw0), int'(e.raw));
                chk(e.name, "stall0",     int'(st0),  int'(e.j | e.b | e.raw));
                chk(e.name, "cycles0",    int'(sc0),  e.cyc);
                chk(e.name, "stall_j1",   int'(j1),   int'(e.j));
                chk(e.name, "stall_b1",   int'(b1),   int'(e.b));
                chk(e.name, "stall_raw1", int'(raw1), int'(e.raw1));
                chk(e.name, "stall1",     int'(st1),  int'(e.j | e.b | e.raw1));
            end
        end
    end

    task automatic clr_in();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_jump = 1'b0; id_branch = 1'b0; wb_addr = '0; wb_en = '0; ld_flag = '0;
        flush = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic set_stage(input int k, input logic [AW-1:0] a, input logic en, input logic ld);
        wb_addr[k*AW +: AW] = a;
        wb_en[k]   = en;
        ld_flag[k] = ld;
    endtask

    // Standard RAW pattern: rs=5 read in ID, stage 2 writes r5
    task automatic raw_s2();
        id_valid = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1;
        set_stage(2, 5'd5, 1'b1, 1'b0);
    endtask

    // Queue the expected post-edge outputs, then advance one cycle
    task automatic step(input logic j, input logic b, input logic raw, input logic r1,
                        input int cyc, input string nm);
        exp_t e;
        e.j = j; e.b = b; e.raw = raw; e.raw1 = r1; e.cyc = cyc; e.name = nm;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        clr_in();
        RST = 1'b1;
        step(0, 0, 0, 0, 0, "reset_a");
        step(0, 0, 0, 0, 0, "reset_b");
        RST = 1'b0;

        // RAW with full detection vs load-use only
        raw_s2();
        step(0, 0, 1, 0, 0, "raw_s2");
        id_rs = 5'd0; set_stage(2, 5'd0, 1'b1, 1'b0);
        step(0, 0, 0, 0, 1, "raw_r0");
        clr_in();
        step(0, 0, 0, 0, 1, "idle_a");

        id_valid = 1'b1; id_rt = 5'd7; id_uses_rt = 1'b1;
        set_stage(0, 5'd7, 1'b1, 1'b1);
        step(0, 0, 1, 1, 1, "load_use");
        ld_flag[0] = 1'b0;
        step(0, 0, 1, 0, 2, "alu_use_ex");
        set_stage(0, 5'd0, 1'b0, 1'b0); set_stage(1, 5'd7, 1'b1, 1'b1);
        step(0, 0, 1, 0, 3, "load_mem");
        clr_in();
        step(0, 0, 0, 0, 4, "idle_b");

        // Jump penalty of one cycle
        id_valid = 1'b1; id_jump = 1'b1;
        step(1, 0, 0, 0, 4, "jump_p1");
        clr_in();
        step(0, 0, 0, 0, 5, "jump_end");
        step(0, 0, 0, 0, 5, "idle_c");

        // Branch penalty of three cycles, RAW match ignored meanwhile
        raw_s2(); id_branch = 1'b1;
        step(0, 1, 0, 0, 5, "br_p1");
        id_branch = 1'b0;
        step(0, 1, 0, 0, 6, "br_p2");
        step(0, 1, 0, 0, 7, "br_p3");
        step(0, 0, 0, 0, 8, "br_exit");
        step(0, 0, 1, 0, 8, "br_raw_after");
        clr_in();
        step(0, 0, 0, 0, 9, "idle_d");

        // Jump wins over branch
        id_valid = 1'b1; id_jump = 1'b1; id_branch = 1'b1;
        step(1, 0, 0, 0, 9, "jb_both");
        clr_in();
        step(0, 0, 0, 0, 10, "jb_end");

        // Flush mid-branch
        id_valid = 1'b1; id_branch = 1'b1;
        step(0, 1, 0, 0, 10, "fl_br_p1");
        clr_in(); flush = 1'b1;
        step(0, 0, 0, 0, 11, "fl_flush");
        flush = 1'b0; raw_s2();
        step(0, 0, 1, 0, 11, "fl_idle_raw");
        clr_in();
        step(0, 0, 0, 0, 12, "idle_e");

        // Reset mid-branch
        id_valid = 1'b1; id_branch = 1'b1;
        step(0, 1, 0, 0, 12, "rst_br_p1");
        clr_in(); RST = 1'b1;
        step(0, 0, 0, 0, 0, "rst_mid");
        RST = 1'b0;
        step(0, 0, 0, 0, 0, "rst_after");

        // Saturating statistic (4-bit instance)
        raw_s2();
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 1, 0, (k - 1 > 15) ? 15 : k - 1, $sformatf("sat_%0d", k));
        end
        clr_in(); stat_clr = 1'b1;
        step(0, 0, 0, 0, 0, "stat_clr");
        stat_clr = 1'b0;
        step(0, 0, 0, 0, 0, "stat_after");

        // Flush overrides a jump in IDLE
        id_valid = 1'b1; id_jump = 1'b1; flush = 1'b1;
        step(0, 0, 0, 0, 0, "fl_jump");
        clr_in();
        step(0, 0, 0, 0, 0, "fl_jump_after");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
